// File: rtl/aes_key_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_pkg
// Description : Shared types and constants for the AES-128 key schedule:
//               round-constant table, FSM state encoding, 32-bit word type.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_key_pkg;

  localparam int NUM_ROUNDS = 10;
  localparam int KEY_W      = 128;

  typedef logic [31:0] word_t;

  // FSM state encoding; FWD is only reachable when forward derivation is built in
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_FWD  = 2'd1;
  localparam state_t ST_EMIT = 2'd2;

  // Rcon[idx] for idx 0..9; anything else returns zero so a stray index is harmless
  function automatic logic [7:0] rcon_of(input logic [3:0] idx);
    logic [7:0] rc;
    rc = 8'h00;
    case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return rc;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_inv_key_round.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_round
// Description : Combinational inverse key-schedule step: given round key r,
//               recovers round key r-1. Output is don't-care for round 0.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_round
  import aes_key_pkg::*;
(
  input  logic [127:0] key,
  input  logic [3:0]   round,
  output logic [127:0] prev_key
);

  word_t w0, w1, w2, w3;
  word_t p3;
  word_t g_out;
  logic [7:0] rcon;

  assign w0 = key[127:96];
  assign w1 = key[95:64];
  assign w2 = key[63:32];
  assign w3 = key[31:0];

  // Last word of the previous key is what the forward step fed into g()
  assign p3 = w3 ^ w2;

  // Rcon index is r-1; round 0 never indexes the table
  assign rcon = (round == 4'd0) ? 8'h00 : rcon_of(round - 4'd1);

  aes_key_g u_g (
    .word_in  (p3),
    .rcon     (rcon),
    .word_out (g_out)
  );

  assign prev_key = {w0 ^ g_out, w1 ^ w0, w2 ^ w1, p3};

endmodule
`default_nettype wire

// File: rtl/aes_key_g.sv
`default_nettype none
// ============================================================================
// Module      : aes_key_g
// Description : Key-expansion g() step: SubWord(RotWord(word_in)) ^ {rcon,24'h0}.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module aes_key_g
  import aes_key_pkg::*;
(
  input  logic [31:0] word_in,
  input  logic [7:0]  rcon,
  output logic [31:0] word_out
);

  // AES S-box, entry 0 in the most significant byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  word_t rot;
  word_t sub;

  // Rotate left by one byte
  assign rot = {word_in[23:0], word_in[31:24]};

  // Byte-wise substitution; entry x sits at bit offset (255-x)*8 = {~x,3'b000}
  generate
    for (genvar b = 0; b < 4; b++) begin : g_sub
      assign sub[b*8 +: 8] = SBOX[{~rot[b*8 +: 8], 3'b000} +: 8];
    end
  endgenerate

  assign word_out = sub ^ {rcon, 24'h000000};

endmodule
`default_nettype wire

// File: rtl/aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : aes_inv_key_schedule
// Description : Sequential reverse AES-128 key schedule. Emits round keys
//               NUM_ROUNDS..0 one per key_valid/key_ready handshake.
//               Optional macro INV_KEY_FWD_DERIVE_EN: key_in is the cipher
//               key and the round-10 key is derived first (10 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module aes_inv_key_schedule #(
  parameter int NUM_ROUNDS = 10,
  parameter int KEY_W      = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             key_ready,
  output logic [KEY_W-1:0] round_key,
  output logic [3:0]       round_num,
  output logic             key_valid,
  output logic             busy,
  output logic             done
);
  import aes_key_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS);

  state_t           state;
  logic [KEY_W-1:0] prev_key;

  aes_inv_key_round u_round (
    .key      (round_key),
    .round    (round_num),
    .prev_key (prev_key)
  );

`ifdef INV_KEY_FWD_DERIVE_EN
  word_t            fwd_g;
  word_t            f0, f1, f2, f3;
  logic [KEY_W-1:0] next_key;

  // During FWD round_num counts rounds already derived, so Rcon index r-1 is round_num
  aes_key_g u_fwd_g (
    .word_in  (round_key[31:0]),
    .rcon     (rcon_of(round_num)),
    .word_out (fwd_g)
  );

  assign f0       = round_key[127:96] ^ fwd_g;
  assign f1       = round_key[95:64] ^ f0;
  assign f2       = round_key[63:32] ^ f1;
  assign f3       = round_key[31:0] ^ f2;
  assign next_key = {f0, f1, f2, f3};
`endif

  // Schedule FSM: key register, round counter and handshake flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      round_key <= '0;
      round_num <= 4'd0;
      key_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            round_key <= key_in;
            busy      <= 1'b1;
`ifdef INV_KEY_FWD_DERIVE_EN
            round_num <= 4'd0;
            state     <= ST_FWD;
`else
            round_num <= LAST_ROUND;
            key_valid <= 1'b1;
            state     <= ST_EMIT;
`endif
          end
        end
`ifdef INV_KEY_FWD_DERIVE_EN
        ST_FWD: begin
          round_key <= next_key;
          round_num <= round_num + 4'd1;
          if (round_num == LAST_ROUND - 4'd1) begin
            key_valid <= 1'b1;
            state     <= ST_EMIT;
          end
        end
`endif
        ST_EMIT: begin
          if (key_valid && key_ready) begin
            if (round_num != 4'd0) begin
              round_key <= prev_key;
              round_num <= round_num - 4'd1;
            end else begin
              key_valid <= 1'b0;
              busy      <= 1'b0;
              done      <= 1'b1;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_aes_inv_key_schedule.sv
`default_nettype none
// ============================================================================
// Module      : tb_aes_inv_key_schedule
// Description : Self-checking bench for aes_inv_key_schedule. Reference keys
//               come from a forward AES-128 expansion whose S-box is built
//               from GF(2^8) inversion plus the affine map.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_aes_inv_key_schedule;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key_in;
  logic         key_ready;
  logic [127:0] round_key;
  logic [3:0]   round_num;
  logic         key_valid;
  logic         busy;
  logic         done;

  aes_inv_key_schedule dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_in    (key_in),
    .key_ready (key_ready),
    .round_key (round_key),
    .round_num (round_num),
    .key_valid (key_valid),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

`ifdef INV_KEY_FWD_DERIVE_EN
  localparam int FIRST_T = 11;
`else
  localparam int FIRST_T = 1;
`endif

  int           n_tests = 0;
  int           n_fail  = 0;
  logic [7:0]   sbox [256];
  logic [127:0] exp_keys [11];
  logic [127:0] got_keys [11];

  typedef struct {
    int           rnd;
    logic [127:0] key;
  } vec_t;
  vec_t tbl [4];

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
    return (v << n) | (v >> (8 - n));
  endfunction

  // S-box from first principles: multiplicative inverse then affine transform
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv, s;
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      sbox[x] = s;
    end
  endtask

  // Standard forward expansion of the cipher key into all eleven round keys
  task automatic expand(input logic [127:0] k0);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // One full schedule with optional corner-case injections; ends at posedge+#1
  task automatic run_sched(input string tag, input logic [127:0] cipher_key, input bit rand_ready,
                           input bit stall7, input bit start5, input bit start_last, input bit rst4);
    int t, stall_cnt, done_cnt, done_t, first_t, nkeys, exp_r;
    bit injected;
    expand(cipher_key);
    for (int r = 0; r < 11; r++) got_keys[r] = 'x;
    t = 0; stall_cnt = 0; done_cnt = 0; done_t = -1; first_t = -1; nkeys = 0; exp_r = 10;
    injected = 1'b0;
`ifdef INV_KEY_FWD_DERIVE_EN
    key_in = cipher_key;
`else
    key_in = exp_keys[10];
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    t = 1;
    while (t <= 80) begin
      start = 1'b0;
      if (done) begin
        done_cnt++;
        done_t = t;
      end else if (done_cnt > 0) begin
        chk({tag, "_idle_after_done"}, {134'd0, key_valid, busy}, 136'd0);
      end
      if (key_valid && first_t < 0) first_t = t;
      if (key_valid) begin
        if (stall7 && round_num == 4'd7 && stall_cnt < 5) begin
          key_ready = 1'b0;
          stall_cnt++;
          chk({tag, "_stall_hold"}, {4'd0, round_num, round_key}, {4'd0, 4'd7, exp_keys[7]});
        end else begin
          key_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        if (start5 && round_num == 4'd5 && !injected) begin
          start = 1'b1;
          injected = 1'b1;
        end
        if (start_last && round_num == 4'd0 && key_ready) start = 1'b1;
        if (rst4 && round_num == 4'd4) begin
          rst = 1'b1;
          @(posedge clk); #1;
          rst = 1'b0;
          chk({tag, "_rst_clear"}, {round_key, round_num, key_valid, busy, done, 1'b0}, 136'd0);
          return;
        end
        if (key_ready) begin
          chk($sformatf("%s_key_r%0d", tag, exp_r), {4'd0, round_num, round_key},
              {4'd0, 4'(exp_r), (exp_r >= 0) ? exp_keys[(exp_r >= 0) ? exp_r : 0] : ~round_key});
          if (round_num <= 4'd10) got_keys[round_num] = round_key;
          nkeys++;
          exp_r--;
        end
      end
      if (done_cnt > 0 && t >= done_t + 3) break;
      @(posedge clk); #1;
      t++;
    end
    start = 1'b0;
    chk({tag, "_nkeys"}, 136'(nkeys), 136'd11);
    chk({tag, "_done_cnt"}, 136'(done_cnt), 136'd1);
    chk({tag, "_first_valid_t"}, 136'(first_t), 136'(FIRST_T));
    if (!rand_ready) chk({tag, "_done_t"}, 136'(done_t), 136'(FIRST_T + 11 + stall_cnt));
  endtask

  initial begin
    tbl[0] = '{10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
    tbl[1] = '{9,  128'hac7766f319fadc2128d12941575c006e};
    tbl[2] = '{1,  128'ha0fafe1788542cb123a339392a6c7605};
    tbl[3] = '{0,  128'h2b7e151628aed2a6abf7158809cf4f3c};

    rst = 1'b1; start = 1'b0; key_in = '0; key_ready = 1'b0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {round_key, round_num, key_valid, busy, done, 1'b0}, 136'd0);
    rst = 1'b0;

    // key_ready high while idle must not disturb anything
    key_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("idle_ready_ignored", {round_num, key_valid, busy, done}, 136'd0);
    end

    // FIPS-197 vector, continuous acceptance, compared to fixed table
    run_sched("fips", tbl[3].key, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      chk($sformatf("fips_tbl_r%0d", tbl[i].rnd), {8'd0, got_keys[tbl[i].rnd]}, {8'd0, tbl[i].key});

    run_sched("stall", tbl[3].key, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    run_sched("start_busy", tbl[3].key, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_sched("start_last", tbl[3].key, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run_sched("abort", tbl[3].key, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run_sched("replay", tbl[3].key, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++)
      run_sched($sformatf("rnd%0d", i), {$urandom, $urandom, $urandom, $urandom},
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/aes_inv_key_schedule.md
Name: aes_inv_key_schedule

Overview:
- Sequential reverse AES-128 key schedule for the decryption datapath.
- Starting from the round-10 key, produces round keys 10, 9, … 0, one per valid/ready handshake.
- Recovers each previous round key by inverting the forward recurrence, using the g() byte-substitute/rotate/Rcon step.
- Sits between key load and the inverse-cipher round controller.

Parameters:
- NUM_ROUNDS, 10, last round index; first key emitted carries this round number.
- KEY_W, 128, round-key width in bits; fixed for AES-128.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a schedule; ignored while busy=1.
- key_in  in  128  round-10 key, sampled when start is accepted; [127:96] = w0.
- key_ready  in  1  downstream accepts round_key this cycle.
- round_key  out  128  current round key, same word order as key_in.
- round_num  out  4  round index of round_key (10 down to 0).
- key_valid  out  1  round_key/round_num valid.
- busy  out  1  schedule in progress.
- done  out  1  one-cycle pulse after the round-0 key is accepted.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; round_key=0, round_num=0, key_valid=0, busy=0, done=0.
- Reset mid-schedule aborts the schedule and returns to these reset values on the next edge.
- FSM states IDLE, EMIT. (FWD exists only with the optional feature.)
- IDLE, start=1: latch key_in, round_num=NUM_ROUNDS, go to EMIT. key_valid=1 and busy=1 from the next cycle (latency 1).
- EMIT: key_valid=1. round_key/round_num hold stable while key_ready=0.
- EMIT, key_valid&key_ready, round_num>0: load the previous key, round_num-1, key_valid stays 1. Back-to-back acceptance yields one key per cycle.
- EMIT, key_valid&key_ready, round_num==0: go to IDLE, key_valid=0, busy=0, done=1 for exactly one cycle. round_key/round_num keep their last values.
- Inverse step, current key words w0..w3, round r:
  - p3 = w3^w2
  - p2 = w2^w1
  - p1 = w1^w0
  - p0 = w0^g(p3, r)
- g(x, r) = SubWord(RotWord(x)) ^ {Rcon[r-1], 24'h0}.
- Rcon[0..9] = 01,02,04,08,10,20,40,80,1b,36. Rcon index is always r-1, for r in 1..10; r=0 never indexes Rcon.
- start while busy: ignored, no effect on state.
- start coincident with the final acceptance: ignored. A new schedule needs start in IDLE.
- key_ready while key_valid=0: ignored.

Optional Feature:
- Macro INV_KEY_FWD_DERIVE_EN.
- Defined:
  - key_in is the cipher key (round 0).
  - start enters FWD and runs the forward schedule, one round per cycle, for r=1..10, using Rcon[r-1]; busy=1 and key_valid=0 throughout.
  - After 10 FWD cycles, go to EMIT with the round-10 key. First key_valid is 11 cycles after start.
  - Reset in FWD returns to IDLE.
- Undefined: no FWD state; key_in is the round-10 key; first key_valid 1 cycle after start.

Decomposition:
- Package aes_key_pkg holds:
  - Rcon table
  - state enum (IDLE, FWD, EMIT)
  - NUM_ROUNDS constant
  - 32-bit word typedef
- Sub-module aes_inv_key_round: combinational previous-round-key computation. Inputs are key and round; it instantiates the existing key-expansion g-function block for g(p3, r).
- The top holds the FSM, key register, round counter and handshake.

Test Plan:
1. FIPS-197 vector: key_in = d014f9a8 c9ee2589 e13f0cc8 b6630ca6, key_ready=1 -> round 10 = key_in; round 9 = ac7766f3 19fadc21 28d12941 575c006e; round 1 = a0fafe17 88542cb1 23a33939 2a6c7605; round 0 = 2b7e1516 28aed2a6 abf71588 09cf4f3c; done pulses once, 12 cycles after start.
2. Backpressure: key_ready held low 5 cycles on round 7 -> round_key/round_num stable, no skipped or repeated round.
3. start pulsed during EMIT at round 5 -> sequence unaffected, exactly 11 keys emitted.
4. rst asserted at round 4 -> next cycle all outputs 0, state IDLE; a new start then replays the full sequence from round 10.
5. key_ready=1 when key_valid=0, and start with key_ready already high -> no spurious advance; round 10 emitted first.
6. INV_KEY_FWD_DERIVE_EN: key_in = 2b7e1516 28aed2a6 abf71588 09cf4f3c -> key_valid first rises 11 cycles after start with d014f9a8 c9ee2589 e13f0cc8 b6630ca6, then the same sequence as scenario 1.
